// File: rtl/tx_flag_collector_pkg.sv
// Shared defaults, FSM state type and width helper for the TX flag collector.
package tx_flag_collector_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_TIMEOUT    = 32;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } fc_state_e;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tx_flag_collector_sync_fifo.sv
// Synchronous FIFO with registered read port; a pop on an empty FIFO is ignored.
module tx_flag_collector_sync_fifo
  import tx_flag_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop_req,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_vld,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      push_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop_req & ~empty;
  // A full FIFO still accepts a write when a pop frees the head slot this cycle.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + PW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_flag_collector.sv
// Turns held TX valids into single captures, buffers them, and closes frames on idle timeout.
module tx_flag_collector
  import tx_flag_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                    REF_CLK,
  input  logic                    RST_REF,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VLD,
  input  logic                    RD_EN,
  input  logic                    CLR_OVF,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic                    RD_VLD,
  output logic                    EMPTY,
  output logic                    FULL,
  output logic [cnt_w(DEPTH)-1:0] COUNT,
  output logic                    FRAME_DONE,
  output logic [LEN_WIDTH-1:0]    FRAME_LEN,
  output logic                    OVERFLOW
);

  localparam int TW = $clog2(TIMEOUT);

  fc_state_e            state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [LEN_WIDTH-1:0] fcnt, fcnt_n;
  logic                 vld_q, cap, acc, drop, fire;

  assign cap  = RX_VLD & ~vld_q;
  assign drop = cap & ~acc;

  tx_flag_collector_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk     (REF_CLK),
    .rst_n   (RST_REF),
    .push    (cap),
    .pop_req (RD_EN),
    .wr_data (RX_DATA),
    .rd_data (RD_DATA),
    .rd_vld  (RD_VLD),
    .full    (FULL),
    .empty   (EMPTY),
    .count   (COUNT),
    .push_ok (acc)
  );

  always_ff @(posedge REF_CLK or negedge RST_REF) begin
    if (!RST_REF) begin
      vld_q      <= 1'b0;
      state      <= IDLE;
      timer      <= '0;
      fcnt       <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_LEN  <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      vld_q      <= RX_VLD;
      state      <= state_n;
      timer      <= timer_n;
      fcnt       <= fcnt_n;
      FRAME_DONE <= fire;
      if (fire) FRAME_LEN <= fcnt;
      if (drop)         OVERFLOW <= 1'b1;
      else if (CLR_OVF) OVERFLOW <= 1'b0;
    end
  end

  // Timeout only advances on low RX_VLD, so a capture always beats a pending close.
  always_comb begin
    state_n = state;
    timer_n = timer;
    fcnt_n  = fcnt;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          state_n = RECV;
          fcnt_n  = LEN_WIDTH'(1);
          timer_n = '0;
        end
      end
      RECV: begin
        if (acc) begin
          fcnt_n  = (fcnt == '1) ? fcnt : fcnt + LEN_WIDTH'(1);
          timer_n = '0;
        end else if (drop) begin
          timer_n = '0;
        end else if (!RX_VLD) begin
          if (timer == TW'(TIMEOUT - 1)) begin
            fire    = 1'b1;
            state_n = IDLE;
            fcnt_n  = '0;
            timer_n = '0;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
